// File: rtl/secded_scrub_counter.sv
// Event counter with each nibble held as an extended Hamming(8,4) codeword, scrubbed every idle cycle.
// Optional error-event counter port enabled by defining SECDED_ERR_COUNT_EN.
module secded_scrub_counter #(
  parameter int WIDTH  = 8,
  parameter int BLOCKS = WIDTH / 4,
  parameter int CNT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_load_value,
  input  logic                  i_inj_valid,
  input  logic [BLOCKS*8-1:0]   i_inj_mask,
  input  logic                  i_clr_err,
  output logic [WIDTH-1:0]      o_counter,
  output logic [BLOCKS*4-1:0]   o_parity,
  output logic                  o_busy,
  output logic                  o_error_detected,
  output logic                  o_uncorrectable
`ifdef SECDED_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0]      o_err_count
`endif
);

  // state    | meaning
  // ENCODE   | count settled, next idle edge writes fresh check bits
  // COUNT    | incrementing, check bits stale, no scrubbing
  // PROTECT  | codeword valid, scrubbed every idle edge
  typedef enum logic [1:0] {ST_ENCODE, ST_COUNT, ST_PROTECT} state_t;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || BLOCKS * 4 != WIDTH) begin : g_bad_width
    $fatal(1, "secded_scrub_counter: WIDTH must be a multiple of 4 and >= 4");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $fatal(1, "secded_scrub_counter: CNT_W must be >= 1");
  end

  state_t                r_state;
  logic [WIDTH-1:0]      r_counter;
  logic [BLOCKS*4-1:0]   r_parity;
  logic                  r_err_det;
  logic                  r_uncorr;
  logic [WIDTH-1:0]      w_fix_d;
  logic [BLOCKS*4-1:0]   w_fix_p;
  logic [WIDTH-1:0]      w_inj_d;
  logic [BLOCKS*4-1:0]   w_inj_p;
  logic [WIDTH-1:0]      w_enc_p;
  logic                  w_single;
  logic                  w_dbl;

  function automatic logic [3:0] f_encode(input logic [3:0] d);
    logic p0, p1, p2;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    return {p0 ^ p1 ^ p2 ^ (^d), p2, p1, p0};
  endfunction

  // Returns {double, single, fix[7:0]} with fix laid out as {p3,p2,p1,p0,d3,d2,d1,d0}.
  function automatic logic [9:0] f_decode(input logic [3:0] d, input logic [3:0] p);
    logic [2:0] s;
    logic       g;
    logic [7:0] fix;
    s[0] = p[0] ^ d[0] ^ d[1] ^ d[3];
    s[1] = p[1] ^ d[0] ^ d[2] ^ d[3];
    s[2] = p[2] ^ d[1] ^ d[2] ^ d[3];
    g    = ^{p, d};
    fix  = '0;
    if (g) begin
      case (s)
        3'd0: fix[7] = 1'b1;
        3'd1: fix[4] = 1'b1;
        3'd2: fix[5] = 1'b1;
        3'd3: fix[0] = 1'b1;
        3'd4: fix[6] = 1'b1;
        3'd5: fix[1] = 1'b1;
        3'd6: fix[2] = 1'b1;
        3'd7: fix[3] = 1'b1;
        default: fix = '0;
      endcase
    end
    return {~g & (s != 3'd0), g, fix};
  endfunction

  always_comb begin : p_decode
    logic [9:0] v_dec;
    w_fix_d  = '0;
    w_fix_p  = '0;
    w_inj_d  = '0;
    w_inj_p  = '0;
    w_enc_p  = '0;
    w_single = 1'b0;
    w_dbl    = 1'b0;
    for (int b = 0; b < BLOCKS; b++) begin
      v_dec              = f_decode(r_counter[4*b +: 4], r_parity[4*b +: 4]);
      w_fix_d[4*b +: 4]  = v_dec[3:0];
      w_fix_p[4*b +: 4]  = v_dec[7:4];
      w_single           = w_single | v_dec[8];
      w_dbl              = w_dbl | v_dec[9];
      w_enc_p[4*b +: 4]  = f_encode(r_counter[4*b +: 4]);
      if (i_inj_valid) begin
        w_inj_d[4*b +: 4] = i_inj_mask[8*b +: 4];
        w_inj_p[4*b +: 4] = i_inj_mask[8*b+4 +: 4];
      end
    end
  end

`ifdef SECDED_ERR_COUNT_EN
  logic [CNT_W-1:0] r_err_count;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_ENCODE;
      r_counter <= '0;
      r_parity  <= '0;
      r_err_det <= 1'b0;
      r_uncorr  <= 1'b0;
`ifdef SECDED_ERR_COUNT_EN
      r_err_count <= '0;
`endif
    end else begin
      r_err_det <= 1'b0;
      if (i_clr_err) r_uncorr <= 1'b0;
      if (i_load) begin
        r_counter <= i_load_value;
        r_state   <= ST_ENCODE;
      end else if (i_enable) begin
        r_counter <= r_counter + {{(WIDTH-1){1'b0}}, 1'b1};
        r_state   <= ST_COUNT;
      end else begin
        case (r_state)
          ST_COUNT: r_state <= ST_ENCODE;
          ST_ENCODE: begin
            r_parity <= w_enc_p;
            r_state  <= ST_PROTECT;
          end
          ST_PROTECT: begin
            // Correction and injection compose on the same edge.
            r_counter <= r_counter ^ w_fix_d ^ w_inj_d;
            r_parity  <= r_parity ^ w_fix_p ^ w_inj_p;
            r_err_det <= w_single;
            if (w_dbl) r_uncorr <= 1'b1;
`ifdef SECDED_ERR_COUNT_EN
            if (w_single && (r_err_count != {CNT_W{1'b1}}))
              r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
          end
          default: r_state <= ST_ENCODE;
        endcase
      end
`ifdef SECDED_ERR_COUNT_EN
      if (i_clr_err) r_err_count <= '0;
`endif
    end
  end

  assign o_counter        = r_counter;
  assign o_parity         = r_parity;
  assign o_busy           = (r_state == ST_PROTECT);
  assign o_error_detected = r_err_det;
  assign o_uncorrectable  = r_uncorr;
`ifdef SECDED_ERR_COUNT_EN
  assign o_err_count      = r_err_count;
`endif

endmodule

// File: tb/tb_secded_scrub_counter.sv
// Self-checking bench for secded_scrub_counter (WIDTH=8): directed scenarios plus randomized
// traffic against a position-indexed Hamming reference model.
module tb_secded_scrub_counter;
  localparam int WIDTH  = 8;
  localparam int BLOCKS = WIDTH / 4;
  localparam int CNT_W  = 2;
  localparam int MD_ENC = 0, MD_CNT = 1, MD_PROT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 i_rst = 1'b0, i_enable = 1'b0, i_load = 1'b0;
  logic [WIDTH-1:0]     i_load_value = '0;
  logic                 i_inj_valid = 1'b0;
  logic [BLOCKS*8-1:0]  i_inj_mask = '0;
  logic                 i_clr_err = 1'b0;
  logic [WIDTH-1:0]     o_counter;
  logic [BLOCKS*4-1:0]  o_parity;
  logic                 o_busy, o_error_detected, o_uncorrectable;
`ifdef SECDED_ERR_COUNT_EN
  logic [CNT_W-1:0]     o_err_count;
  int                   m_ec = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0]     m_cnt = '0;
  logic [BLOCKS*4-1:0]  m_par = '0;
  int                   m_mode = MD_ENC;
  bit                   m_det = 0, m_unc = 0;

  secded_scrub_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_load(i_load),
    .i_load_value(i_load_value), .i_inj_valid(i_inj_valid), .i_inj_mask(i_inj_mask),
    .i_clr_err(i_clr_err), .o_counter(o_counter), .o_parity(o_parity), .o_busy(o_busy),
    .o_error_detected(o_error_detected), .o_uncorrectable(o_uncorrectable)
`ifdef SECDED_ERR_COUNT_EN
    , .o_err_count(o_err_count)
`endif
  );

  // Codeword as bits indexed by Hamming position: 0=p3,1=p0,2=p1,3=d0,4=p2,5=d1,6=d2,7=d3.
  function automatic logic [3:0] ref_encode(input logic [3:0] d);
    bit b[8];
    int s;
    bit g;
    for (int i = 0; i < 8; i++) b[i] = 0;
    b[3] = d[0]; b[5] = d[1]; b[6] = d[2]; b[7] = d[3];
    s = 0;
    for (int i = 1; i < 8; i++) if (b[i]) s ^= i;
    b[1] = (s & 1) != 0; b[2] = (s & 2) != 0; b[4] = (s & 4) != 0;
    g = 0;
    for (int i = 1; i < 8; i++) g ^= b[i];
    b[0] = g;
    return {b[0], b[4], b[2], b[1]};
  endfunction

  function automatic void ref_scrub(input logic [3:0] d, input logic [3:0] p,
                                    output logic [3:0] nd, output logic [3:0] np,
                                    output bit single, output bit dbl);
    bit b[8];
    int s;
    bit g;
    b[0] = p[3]; b[1] = p[0]; b[2] = p[1]; b[3] = d[0];
    b[4] = p[2]; b[5] = d[1]; b[6] = d[2]; b[7] = d[3];
    s = 0; g = 0;
    for (int i = 0; i < 8; i++) if (b[i]) begin s ^= i; g ^= 1; end
    single = g;
    dbl    = !g && (s != 0);
    if (g) b[s] = !b[s];
    nd = {b[7], b[6], b[5], b[3]};
    np = {b[0], b[4], b[2], b[1]};
  endfunction

  task automatic model_step();
    logic [3:0] nd, np;
    bit sg, db, any_s, any_d;
    if (i_rst) begin
      m_cnt = '0; m_par = '0; m_mode = MD_ENC; m_det = 0; m_unc = 0;
`ifdef SECDED_ERR_COUNT_EN
      m_ec = 0;
`endif
      return;
    end
    m_det = 0; any_s = 0; any_d = 0;
    if (i_load) begin
      m_cnt = i_load_value; m_mode = MD_ENC;
    end else if (i_enable) begin
      m_cnt = m_cnt + 1'b1; m_mode = MD_CNT;
    end else if (m_mode == MD_CNT) begin
      m_mode = MD_ENC;
    end else if (m_mode == MD_ENC) begin
      for (int b = 0; b < BLOCKS; b++) m_par[4*b +: 4] = ref_encode(m_cnt[4*b +: 4]);
      m_mode = MD_PROT;
    end else begin
      for (int b = 0; b < BLOCKS; b++) begin
        ref_scrub(m_cnt[4*b +: 4], m_par[4*b +: 4], nd, np, sg, db);
        if (i_inj_valid) begin
          nd = nd ^ i_inj_mask[8*b +: 4];
          np = np ^ i_inj_mask[8*b+4 +: 4];
        end
        m_cnt[4*b +: 4] = nd;
        m_par[4*b +: 4] = np;
        any_s |= sg; any_d |= db;
      end
      m_det = any_s;
`ifdef SECDED_ERR_COUNT_EN
      if (any_s && m_ec < (1 << CNT_W) - 1) m_ec++;
`endif
    end
    if (i_clr_err) begin
      m_unc = 0;
`ifdef SECDED_ERR_COUNT_EN
      m_ec = 0;
`endif
    end
    if (any_d) m_unc = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    i_rst = 0; i_enable = 0; i_load = 0; i_inj_valid = 0; i_inj_mask = '0; i_clr_err = 0;
  endtask

  task automatic test_reset();
    idle(); i_rst = 1; tick(); tick(); i_rst = 0;
    total++; if (o_counter !== 8'h00) begin bad++; $display("FAIL reset_counter got=%0h want=0", o_counter); end
    total++; if (o_parity !== 8'h00) begin bad++; $display("FAIL reset_parity got=%0h want=0", o_parity); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++; if (o_error_detected !== 1'b0) begin bad++; $display("FAIL reset_det got=%b want=0", o_error_detected); end
    total++; if (o_uncorrectable !== 1'b0) begin bad++; $display("FAIL reset_unc got=%b want=0", o_uncorrectable); end
    tick();
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL reset_busy_2nd got=%b want=1", o_busy); end
  endtask

  task automatic test_count();
    i_enable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL count_busy cyc=%0d got=%b want=0", i, o_busy); end
    end
    i_enable = 0;
    total++; if (o_counter !== 8'h05) begin bad++; $display("FAIL count_value got=%0h want=05", o_counter); end
    tick();
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL encode_busy got=%b want=0", o_busy); end
    tick();
    total++; if (o_parity !== 8'h05) begin bad++; $display("FAIL encode_parity got=%0h want=05", o_parity); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL protect_busy got=%b want=1", o_busy); end
  endtask

  task automatic test_single_data();
    i_inj_valid = 1; i_inj_mask = 16'h0004; tick(); idle();
    total++; if (o_counter !== 8'h01) begin bad++; $display("FAIL sd_injected got=%0h want=01", o_counter); end
    total++; if (o_error_detected !== 1'b0) begin bad++; $display("FAIL sd_det_early got=%b want=0", o_error_detected); end
    tick();
    total++; if (o_counter !== 8'h05) begin bad++; $display("FAIL sd_fixed got=%0h want=05", o_counter); end
    total++; if (o_error_detected !== 1'b1) begin bad++; $display("FAIL sd_det got=%b want=1", o_error_detected); end
    total++; if (o_uncorrectable !== 1'b0) begin bad++; $display("FAIL sd_unc got=%b want=0", o_uncorrectable); end
    tick();
    total++; if (o_error_detected !== 1'b0) begin bad++; $display("FAIL sd_det_end got=%b want=0", o_error_detected); end
  endtask

  task automatic test_single_parity();
    i_inj_valid = 1; i_inj_mask = 16'h0020; tick(); idle();
    total++; if (o_parity !== 8'h07) begin bad++; $display("FAIL sp_injected got=%0h want=07", o_parity); end
    tick();
    total++; if (o_parity !== 8'h05) begin bad++; $display("FAIL sp_fixed got=%0h want=05", o_parity); end
    total++; if (o_counter !== 8'h05) begin bad++; $display("FAIL sp_counter got=%0h want=05", o_counter); end
    total++; if (o_error_detected !== 1'b1) begin bad++; $display("FAIL sp_det got=%b want=1", o_error_detected); end
    tick();
    total++; if (o_error_detected !== 1'b0) begin bad++; $display("FAIL sp_det_end got=%b want=0", o_error_detected); end
  endtask

  task automatic test_double();
    i_inj_valid = 1; i_inj_mask = 16'h0003; tick(); idle();
    total++; if (o_counter !== 8'h06) begin bad++; $display("FAIL dbl_injected got=%0h want=06", o_counter); end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (o_uncorrectable !== 1'b1 || o_counter !== 8'h06 || o_error_detected !== 1'b0) begin
        bad++; $display("FAIL dbl_hold cyc=%0d got unc=%b cnt=%0h det=%b want unc=1 cnt=06 det=0",
                        i, o_uncorrectable, o_counter, o_error_detected);
      end
    end
    i_clr_err = 1; tick(); idle();
    total++; if (o_uncorrectable !== 1'b1) begin bad++; $display("FAIL dbl_set_wins got=%b want=1", o_uncorrectable); end
    i_load = 1; i_load_value = 8'h05; i_clr_err = 1; tick(); idle();
    total++; if (o_uncorrectable !== 1'b0) begin bad++; $display("FAIL dbl_clr got=%b want=0", o_uncorrectable); end
    tick();
    total++; if (o_busy !== 1'b1 || o_parity !== 8'h05 || o_counter !== 8'h05) begin
      bad++; $display("FAIL dbl_reprotect got busy=%b par=%0h cnt=%0h want 1 05 05", o_busy, o_parity, o_counter);
    end
  endtask

  task automatic test_two_blocks();
    int pulses;
    i_inj_valid = 1; i_inj_mask = 16'h0101; tick(); idle();
    total++; if (o_counter !== 8'h14) begin bad++; $display("FAIL tb_injected got=%0h want=14", o_counter); end
    tick();
    total++; if (o_counter !== 8'h05) begin bad++; $display("FAIL tb_fixed got=%0h want=05", o_counter); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_error_detected === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL tb_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_wrap();
    i_load = 1; i_load_value = 8'hFE; tick(); idle();
    i_enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL wrap_busy cyc=%0d got=%b want=0", i, o_busy); end
    end
    total++; if (o_counter !== 8'h01) begin bad++; $display("FAIL wrap_value got=%0h want=01", o_counter); end
    i_enable = 0; tick();
    i_enable = 1; tick();
    total++; if (o_counter !== 8'h02 || o_busy !== 1'b0) begin
      bad++; $display("FAIL reenable got cnt=%0h busy=%b want 02 0", o_counter, o_busy);
    end
    i_enable = 0; tick(); tick();
    total++; if (o_parity !== 8'h0D || o_busy !== 1'b1) begin
      bad++; $display("FAIL wrap_protect got par=%0h busy=%b want 0d 1", o_parity, o_busy);
    end
  endtask

  task automatic test_inject_ignored();
    i_load = 1; i_load_value = 8'h33; tick(); idle();
    i_inj_valid = 1; i_inj_mask = 16'hFFFF; tick(); idle();
    total++; if (o_counter !== 8'h33 || o_parity !== 8'h66) begin
      bad++; $display("FAIL inj_encode got cnt=%0h par=%0h want 33 66", o_counter, o_parity);
    end
    i_enable = 1; i_inj_valid = 1; i_inj_mask = 16'h0001; tick(); idle();
    tick(); tick(); tick();
    total++; if (o_counter !== 8'h34 || o_parity !== 8'h6E || o_error_detected !== 1'b0) begin
      bad++; $display("FAIL inj_enable got cnt=%0h par=%0h det=%b want 34 6e 0", o_counter, o_parity, o_error_detected);
    end
  endtask

`ifdef SECDED_ERR_COUNT_EN
  task automatic test_err_count();
    i_clr_err = 1; tick(); idle();
    total++; if (o_err_count !== 2'd0) begin bad++; $display("FAIL ec_clr got=%0d want=0", o_err_count); end
    for (int i = 0; i < 4; i++) begin
      i_inj_valid = 1; i_inj_mask = 16'h0001; tick(); idle(); tick();
    end
    total++; if (o_err_count !== 2'd3) begin bad++; $display("FAIL ec_sat got=%0d want=3", o_err_count); end
    i_clr_err = 1; tick(); idle();
    total++; if (o_err_count !== 2'd0) begin bad++; $display("FAIL ec_clr2 got=%0d want=0", o_err_count); end
  endtask
`endif

  task automatic test_random();
    int r;
    for (int n = 0; n < 600; n++) begin
      idle();
      i_rst        = ($urandom_range(99) == 0);
      i_load       = ($urandom_range(99) < 5);
      i_load_value = 8'($urandom);
      i_enable     = ($urandom_range(99) < 15);
      i_clr_err    = ($urandom_range(99) < 5);
      i_inj_valid  = ($urandom_range(99) < 25);
      r = $urandom_range(3);
      if (r == 0)      i_inj_mask = 16'(1) << $urandom_range(15);
      else if (r == 1) i_inj_mask = (16'(1) << $urandom_range(7)) | (16'(1) << $urandom_range(15, 8));
      else if (r == 2) i_inj_mask = 16'(3) << (2 * $urandom_range(6));
      else             i_inj_mask = 16'($urandom);
      tick();
      total++; if (o_counter !== m_cnt) begin bad++; $display("FAIL rnd_counter n=%0d got=%0h want=%0h", n, o_counter, m_cnt); end
      total++; if (o_parity !== m_par) begin bad++; $display("FAIL rnd_parity n=%0d got=%0h want=%0h", n, o_parity, m_par); end
      total++; if (o_busy !== (m_mode == MD_PROT)) begin bad++; $display("FAIL rnd_busy n=%0d got=%b want=%b", n, o_busy, m_mode == MD_PROT); end
      total++; if (o_error_detected !== m_det) begin bad++; $display("FAIL rnd_det n=%0d got=%b want=%b", n, o_error_detected, m_det); end
      total++; if (o_uncorrectable !== m_unc) begin bad++; $display("FAIL rnd_unc n=%0d got=%b want=%b", n, o_uncorrectable, m_unc); end
`ifdef SECDED_ERR_COUNT_EN
      total++; if (int'(o_err_count) !== m_ec) begin bad++; $display("FAIL rnd_ec n=%0d got=%0d want=%0d", n, o_err_count, m_ec); end
`endif
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_count();
    test_single_data();
    test_single_parity();
    test_double();
    test_two_blocks();
    test_wrap();
    test_inject_ignored();
`ifdef SECDED_ERR_COUNT_EN
    test_err_count();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
